load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port req_valid, input, 1 bit: request offered by the execute stage.
REQ-004 SHALL have port req_ready, output, 1 bit: unit can accept a request.
REQ-005 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have port req_byte, input, 1 bit: 1 = byte access, 0 = 16-bit word access.
REQ-007 SHALL have port req_signed, input, 1 bit: sign-extend a byte load; ignored otherwise.
REQ-008 SHALL have port req_addr, input, 8 bits: byte address.
REQ-009 SHALL have port req_wdata, input, 16 bits: store data; a byte store uses bits [7:0].
REQ-010 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, 16 bits: load result, 0 for stores and errors.
REQ-012 SHALL have port resp_err, output, 1 bit: misaligned-access error, valid with resp_valid.
REQ-013 SHALL have port mem_read, output, 1 bit: data memory read enable.
REQ-014 SHALL have port mem_write, output, 1 bit: data memory write enable.
REQ-015 SHALL have port mem_addr, output, 8 bits: data memory address.
REQ-016 SHALL have port mem_wdata, output, 16 bits: data memory write data, big-endian {mem[a], mem[a+1]}.
REQ-017 SHALL have port mem_rdata, input, 16 bits: combinational memory read data {mem[a], mem[a+1]}.
REQ-018 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-019 SHALL implement the states IDLE, LD, ST, RMW_RD and RMW_WR.
REQ-020 SHALL assert req_ready only in IDLE; a request is accepted on a rising edge with req_valid & req_ready.
REQ-021 SHALL latch addr, wdata, byte, signed and write at acceptance; input changes afterwards have no effect.
REQ-022 SHALL route an accepted request as follows: word load to LD; word store to ST; byte load to LD; byte store to RMW_RD.
REQ-023 SHALL treat a word access with addr = 0xFF as an error: no memory cycle, return to IDLE, and resp_valid=1, resp_err=1, resp_rdata=0 in the next cycle.
REQ-024 SHALL use the effective word address 0xFE for a byte access at 0xFF, with the byte in the low lane; for any other byte address a, it SHALL use address a with the byte in the high lane.
REQ-025 SHALL drive mem_read=1 and mem_addr=effective address for the whole of LD, then capture mem_rdata at the edge that leaves LD.
REQ-026 SHALL return the full word for a word load; for a byte load it SHALL return the selected lane, zero-extended, or sign-extended (from bit 7) when req_signed=1.
REQ-027 SHALL drive mem_write=1 in ST, with mem_addr = addr and mem_wdata = latched wdata.
REQ-028 SHALL, in RMW_RD, drive mem_read=1 and capture mem_rdata into a merge register.
REQ-029 SHALL, in RMW_WR, drive mem_write=1 with the merge word, its selected lane replaced by wdata[7:0] and the other lane unchanged.
REQ-030 SHALL drive mem_read and mem_write from the current state only; both SHALL never be high together; both SHALL be 0 in IDLE.
REQ-031 SHALL drive mem_addr and mem_wdata to 0 in IDLE.
REQ-032 SHALL register resp_valid high for exactly one cycle, the cycle after leaving LD, ST or RMW_WR (or after an error accept), with the state already IDLE.
REQ-033 SHALL allow a new request to be accepted in the same cycle that resp_valid is high.
REQ-034 SHALL give these latencies from the accept edge to resp_valid: error 1 cycle; word or byte load 2; word store 2; byte store 3.
REQ-035 SHALL hold resp_rdata and resp_err at 0 whenever resp_valid=0.

Reset
REQ-036 SHALL, on reset_n=0, immediately force state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, busy=0 and all latched and merge registers to 0; mem_read, mem_write, mem_addr and mem_wdata SHALL go to 0 without waiting for a clock edge.
REQ-037 SHALL abandon an in-flight operation when reset is applied mid-operation: no response, and no later memory write.
REQ-038 SHALL drive req_ready=1 in the first cycle after reset_n deasserts.

Verification (memory reset image: 0x00..0x09 = 56 38 00 00 12 43 DE BE EF AD, rest 00)
REQ-039 SHALL be covered by: word load addr 0x00 -> LD, then resp_valid with resp_rdata=0x5638, resp_err=0, 2 cycles after accept.
REQ-040 SHALL be covered by: byte load addr 0x06, signed=1 -> 0xFFDE; same with signed=0 -> 0x00DE.
REQ-041 SHALL be covered by: byte store 0x77 to addr 0x05 -> RMW_WR drives mem_addr=0x05, mem_wdata=0x77DE; a following word load at 0x04 -> 0x1277.
REQ-042 SHALL be covered by: word load or store at 0xFF -> resp_err=1, resp_rdata=0 after 1 cycle, with mem_read=mem_write=0 throughout.
REQ-043 SHALL be covered by: byte store 0xAB to addr 0xFF -> mem_addr=0xFE, mem_wdata=0x00AB; a byte load at 0xFF -> 0x00AB.
REQ-044 SHALL be covered by: reset_n pulsed low during RMW_RD -> mem_read drops at once, no mem_write, no resp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: 16-bit big-endian word and byte accesses to a byte-addressed
// data memory; byte stores use read-modify-write, misaligned word accesses error out.
module load_store_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic        req_signed,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 8;

  typedef enum logic [2:0] {IDLE, LD, ST, RMW_RD, RMW_WR} state_t;

  state_t        state;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          byte_q;
  logic          signed_q;
  logic          write_q;
  logic [DW-1:0] merge_q;

  logic          low_lane_c;
  logic [AW-1:0] eff_addr_c;
  logic [BW-1:0] lane_c;
  logic [DW-1:0] load_data_c;
  logic [DW-1:0] merged_c;

  // A byte at the last address lives in the low lane of the word at 0xFE.
  always_comb begin
    low_lane_c  = (addr_q == 8'hFF);
    eff_addr_c  = low_lane_c ? 8'hFE : addr_q;
    lane_c      = low_lane_c ? mem_rdata[7:0] : mem_rdata[15:8];
    load_data_c = mem_rdata;
    if (byte_q)
      load_data_c = signed_q ? {{BW{lane_c[BW-1]}}, lane_c} : {{BW{1'b0}}, lane_c};
    merged_c    = low_lane_c ? {merge_q[15:8], wdata_q[7:0]} : {wdata_q[7:0], merge_q[7:0]};
  end

  // Memory strobes are decoded from the state register alone.
  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      LD, RMW_RD: begin
        mem_read = 1'b1;
        mem_addr = eff_addr_c;
      end
      ST: begin
        mem_write = write_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end
      RMW_WR: begin
        mem_write = write_q;
        mem_addr  = eff_addr_c;
        mem_wdata = merged_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      byte_q     <= 1'b0;
      signed_q   <= 1'b0;
      write_q    <= 1'b0;
      merge_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            byte_q   <= req_byte;
            signed_q <= req_signed;
            write_q  <= req_write;
            if (!req_byte && (req_addr == 8'hFF)) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (!req_write) begin
              state <= LD;
            end else if (!req_byte) begin
              state <= ST;
            end else begin
              state <= RMW_RD;
            end
          end
        end
        LD: begin
          resp_valid <= 1'b1;
          resp_rdata <= load_data_c;
          state      <= IDLE;
        end
        ST: begin
          resp_valid <= 1'b1;
          state      <= IDLE;
        end
        RMW_RD: begin
          merge_q <= mem_rdata;
          state   <= RMW_WR;
        end
        RMW_WR: begin
          resp_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
